// File: rtl/vanilla_counting_scoreboard.sv
// Counting register scoreboard: tracks outstanding writes per register and
// raises a stall for RAW hazards or when a register's write budget is exhausted.
module vanilla_counting_scoreboard #(
  parameter int els_p             = 32,
  parameter int num_src_port_p    = 2,
  parameter int num_score_port_p  = 1,
  parameter int num_clear_port_p  = 1,
  parameter int max_out_p         = 3,
  parameter int x0_tied_to_zero_p = 0,
  parameter int sim_errors_p      = 1,
  localparam int id_width_lp      = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int cnt_width_lp     = (max_out_p + 1 > 1) ? $clog2(max_out_p + 1) : 1
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [num_src_port_p-1:0][id_width_lp-1:0]   src_id_i,
  input  logic [num_src_port_p-1:0]                    op_reads_rf_i,
  input  logic [id_width_lp-1:0]                       dest_id_i,
  input  logic                                         op_writes_rf_i,
  input  logic [num_score_port_p-1:0]                  score_i,
  input  logic [num_score_port_p-1:0][id_width_lp-1:0] score_id_i,
  input  logic [num_clear_port_p-1:0]                  clear_i,
  input  logic [num_clear_port_p-1:0][id_width_lp-1:0] clear_id_i,
  output logic                                         dependency_o,
  output logic                                         pending_o,
  output logic [els_p-1:0][cnt_width_lp-1:0]           cnt_o
);

  // Wide enough for count + all scores, with a spare top bit acting as sign.
  localparam int sum_w_lp = $clog2(max_out_p + num_score_port_p + num_clear_port_p + 1) + 1;
  typedef logic [sum_w_lp-1:0] sum_t;

  logic [els_p-1:0][cnt_width_lp-1:0] cnt_r;
  logic [els_p-1:0][cnt_width_lp-1:0] cnt_n;
  sum_t                               s_cnt [els_p];
  sum_t                               c_cnt [els_p];
  sum_t                               eff   [els_p];
  logic [els_p-1:0]                   ovf;
  logic [els_p-1:0]                   unf;
  logic [num_src_port_p-1:0]          raw;
  logic                               waw;

  function automatic logic [cnt_width_lp-1:0] sat_cnt(input sum_t v);
    if (v[sum_w_lp-1])
      return '0;
    else if (v > sum_t'(max_out_p))
      return cnt_width_lp'(max_out_p);
    else
      return v[cnt_width_lp-1:0];
  endfunction

  always_comb begin
    sum_t nxt;
    nxt   = '0;
    cnt_n = cnt_r;
    ovf   = '0;
    unf   = '0;
    for (int i = 0; i < els_p; i++) begin
      s_cnt[i] = '0;
      c_cnt[i] = '0;
      for (int p = 0; p < num_score_port_p; p++)
        if (score_i[p] && (score_id_i[p] == id_width_lp'(i)))
          s_cnt[i] = s_cnt[i] + sum_t'(1);
      for (int p = 0; p < num_clear_port_p; p++)
        if (clear_i[p] && (clear_id_i[p] == id_width_lp'(i)))
          c_cnt[i] = c_cnt[i] + sum_t'(1);
      if ((x0_tied_to_zero_p != 0) && (i == 0)) begin
        s_cnt[i] = '0;
        c_cnt[i] = '0;
      end
      // eff excludes this cycle's scores so the late score path stays short
      eff[i]   = (sum_t'(cnt_r[i]) >= c_cnt[i]) ? (sum_t'(cnt_r[i]) - c_cnt[i]) : '0;
      nxt      = sum_t'(cnt_r[i]) + s_cnt[i] - c_cnt[i];
      unf[i]   = nxt[sum_w_lp-1];
      ovf[i]   = !nxt[sum_w_lp-1] && (nxt > sum_t'(max_out_p));
      cnt_n[i] = sat_cnt(nxt);
    end
  end

  always_comb begin
    raw = '0;
    for (int j = 0; j < num_src_port_p; j++)
      raw[j] = op_reads_rf_i[j]
             && ((eff[src_id_i[j]] != '0) || (s_cnt[src_id_i[j]] != '0));
    waw = op_writes_rf_i
        && ((eff[dest_id_i] + s_cnt[dest_id_i]) >= sum_t'(max_out_p));
  end

  assign dependency_o = (|raw) | waw;

  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < els_p; i++)
      pending_o = pending_o | (cnt_r[i] != '0);
  end

  assign cnt_o = cnt_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_r <= '0;
    else
      cnt_r <= cnt_n;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && (sim_errors_p != 0)) begin
      for (int i = 0; i < els_p; i++) begin
        if (ovf[i]) $error("scoreboard overflow on register %0d", i);
        if (unf[i]) $error("scoreboard underflow on register %0d", i);
      end
    end
  end

endmodule
